// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Fetch/issue controller for the 16-bit bus processor (mv/mvi/add/sub datapath).
// Reads instruction words from a synchronous program memory (data valid one
// cycle after the read strobe), presents them on DIN with a one-cycle Run
// pulse, supplies the mvi immediate on the cycle after issue, waits for Done,
// then advances the PC. Adds Start/Halt control, a HALT opcode (111),
// illegal-opcode trapping (100-110) and a Done watchdog. Fault is sticky and
// is cleared only by reset.
//
// Parameters:
//   ADDR_W    program memory address width; PC wraps modulo 2^ADDR_W
//   MAX_WAIT  EXEC cycles allowed without Done before Fault is raised
//
// Ports:
//   Clock       in   system clock, rising edge
//   Resetn      in   asynchronous active-low reset
//   Start       in   one-cycle pulse, starts at PC=0 from IDLE
//   Halt        in   level, sampled at instruction retire
//   Step        in   (SEQ_SINGLE_STEP_EN only) advances out of PAUSE
//   mem_addr    out  program memory address
//   mem_rd      out  program memory read strobe
//   mem_rdata   in   program memory read data, valid one cycle after mem_rd
//   DIN         out  word driven to the processor
//   Run         out  one-cycle issue pulse
//   Done        in   processor instruction-complete flag
//   Busy        out  high in every state except IDLE and FAULT
//   PC          out  address of the current instruction
//   InstrCount  out  retired-instruction counter (wraps)
//   Fault       out  sticky illegal-opcode / watchdog flag
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   When defined, adds the Step input and a PAUSE state entered after every
//   retire with Halt low. Step leaves PAUSE to fetch the next instruction,
//   Halt leaves PAUSE to IDLE. When undefined, retire goes straight to FETCH.
// -----------------------------------------------------------------------------

module instr_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Halt,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount,
    output logic              Fault
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // IDLE     | waiting for Start; PC and InstrCount hold their last values
    // FETCH    | mem_rd high, mem_addr = PC
    // F_WAIT   | instruction word arrives; decode opcode
    // IMM_RD   | mem_rd high, mem_addr = PC+1 (mvi immediate)
    // IMM_WAIT | immediate word arrives
    // ISSUE    | DIN = instruction, Run high, watchdog reloaded
    // EXEC     | DIN = immediate (mvi) or instruction; wait for Done
    // FAULT    | Fault high, all outputs frozen until reset
    // PAUSE    | single-step build only: wait for Step or Halt

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_F_WAIT   = 4'd2,
        S_IMM_RD   = 4'd3,
        S_IMM_WAIT = 4'd4,
        S_ISSUE    = 4'd5,
        S_EXEC     = 4'd6,
        S_FAULT    = 4'd7
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_PAUSE    = 4'd8
`endif
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Watchdog is a down-counter loaded with MAX_WAIT-1 during ISSUE; the
    // EXEC cycle that sees zero is the MAX_WAIT-th one.
    localparam int              WD_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MAX_WAIT - 1);

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   pc_q,     pc_d;
    logic [15:0]         cnt_q,    cnt_d;
    logic [15:0]         instr_q,  instr_d;
    logic [15:0]         imm_q,    imm_d;
    logic [15:0]         din_q,    din_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                rd_q,     rd_d;
    logic                run_q,    run_d;
    logic                busy_q,   busy_d;
    logic                fault_q,  fault_d;
    logic [WD_W-1:0]     wd_q,     wd_d;

    logic                is_mvi;
    logic [ADDR_W-1:0]   pc_next;

    assign is_mvi  = (instr_q[15:13] == OP_MVI);
    assign pc_next = pc_q + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        din_d   = din_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        run_d   = 1'b0;
        fault_d = fault_q;
        wd_d    = wd_q;

        // Outputs are registered, so each transition sets up the values that
        // the destination state presents during its own cycle.
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    rd_d    = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_F_WAIT;
            end

            S_F_WAIT: begin
                instr_d = mem_rdata;
                case (mem_rdata[15:13])
                    OP_HALT: begin
                        state_d = S_IDLE;
                    end
                    OP_MVI: begin
                        state_d = S_IMM_RD;
                        addr_d  = pc_q + ADDR_W'(1);
                        rd_d    = 1'b1;
                    end
                    OP_MV, OP_ADD, OP_SUB: begin
                        state_d = S_ISSUE;
                        din_d   = mem_rdata;
                        run_d   = 1'b1;
                    end
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                endcase
            end

            S_IMM_RD: begin
                state_d = S_IMM_WAIT;
            end

            S_IMM_WAIT: begin
                imm_d   = mem_rdata;
                state_d = S_ISSUE;
                din_d   = instr_q;
                run_d   = 1'b1;
            end

            S_ISSUE: begin
                // Done during the Run cycle is not looked at here.
                state_d = S_EXEC;
                wd_d    = WD_LOAD;
                if (is_mvi) begin
                    din_d = imm_q;
                end
            end

            S_EXEC: begin
                // Done is checked before the watchdog so a Done on the last
                // allowed cycle still retires.
                if (Done) begin
                    pc_d  = pc_next;
                    cnt_d = cnt_q + 16'd1;
                    if (Halt) begin
                        state_d = S_IDLE;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_d = S_PAUSE;
`else
                        state_d = S_FETCH;
                        addr_d  = pc_next;
                        rd_d    = 1'b1;
`endif
                    end
                end else if (wd_q == '0) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (Halt) begin
                    state_d = S_IDLE;
                end else if (Step) begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                    rd_d    = 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_FAULT);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            wd_q    <= wd_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rd     = rd_q;
    assign DIN        = din_q;
    assign Run        = run_q;
    assign Busy       = busy_q;
    assign PC         = pc_q;
    assign InstrCount = cnt_q;
    assign Fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer (default build). A table of small
// programs with hand-derived results, a few hand-written sequences (reset
// mid-EXEC, PC wrap with mvi at the last address, sticky fault) and random
// programs checked against a cycle-level reference model that walks the
// program from the opcode rules.
// -----------------------------------------------------------------------------

module tb_instr_sequencer;

    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 15;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int NDL      = 64;

    logic              Clock  = 1'b0;
    logic              Resetn = 1'b0;
    logic              Start  = 1'b0;
    logic              Halt   = 1'b0;
    logic              Done   = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata = 16'h0;
    logic [15:0]       DIN;
    logic              Run;
    logic              Busy;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       InstrCount;
    logic              Fault;

    instr_sequencer #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Halt       (Halt),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .DIN        (DIN),
        .Run        (Run),
        .Done       (Done),
        .Busy       (Busy),
        .PC         (PC),
        .InstrCount (InstrCount),
        .Fault      (Fault)
    );

    always #5 Clock = ~Clock;

    // Synchronous program memory.
    logic [15:0] mem [DEPTH];
    always @(posedge Clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Processor stand-in: Done goes high for one cycle, dl[k] cycles after
    // the k-th Run (0 = during the Run cycle itself). Halt rises once the
    // halt_n-th instruction has been issued.
    int          dl [NDL];
    int          halt_n    = 1000;
    int          runs_seen = 0;
    int          since_run = -1;
    int          reads     = 0;
    int          run_pairs = 0;
    bit          prev_run  = 1'b0;
    int          act_run [$];
    logic [15:0] act_w0  [$];
    logic [15:0] act_w1  [$];

    always @(negedge Clock) begin
        int cur;
        if (prev_run) act_w1.push_back(DIN);
        if (Run) begin
            if (prev_run) run_pairs++;
            runs_seen++;
            act_run.push_back(cyc);
            act_w0.push_back(DIN);
            since_run = 0;
        end else if (since_run >= 0) begin
            since_run++;
        end
        prev_run = Run;
        if (mem_rd) reads++;
        cur  = (runs_seen >= 1 && runs_seen <= NDL) ? dl[runs_seen-1] : -100;
        Done = (since_run >= 0) && (since_run == cur);
        Halt = (runs_seen >= halt_n);
    end

    // Reference model results.
    int          exp_run [$];
    logic [15:0] exp_w0  [$];
    logic [15:0] exp_w1  [$];
    int          exp_pc, exp_cnt, exp_end, exp_reads;
    bit          exp_fault;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Walks the program: each instruction occupies FETCH+F_WAIT (+2 for the
    // mvi immediate read), then one Run cycle, then EXEC until Done.
    task automatic model_run(input int f);
        int          pc, t, op, run;
        bit          mvi, stop;
        logic [15:0] w;
        pc = 0; t = f; stop = 0;
        exp_run.delete(); exp_w0.delete(); exp_w1.delete();
        exp_cnt = 0; exp_fault = 0; exp_reads = 0; exp_end = -1;
        for (int i = 0; i < NDL && !stop; i++) begin
            w  = mem[pc];
            op = int'(w[15:13]);
            exp_reads++;
            if (op == 7) begin
                exp_end = t + 2; stop = 1;
            end else if (op >= 4) begin
                exp_fault = 1; exp_end = t + 2; stop = 1;
            end else begin
                mvi = (op == 1);
                run = t + (mvi ? 4 : 2);
                if (mvi) exp_reads++;
                exp_run.push_back(run);
                exp_w0.push_back(w);
                exp_w1.push_back(mvi ? mem[(pc + 1) % DEPTH] : w);
                if (dl[i] < 1 || dl[i] > MAX_WAIT) begin
                    exp_fault = 1; exp_end = run + MAX_WAIT + 1; stop = 1;
                end else begin
                    pc = (pc + (mvi ? 2 : 1)) % DEPTH;
                    exp_cnt++;
                    t = run + dl[i] + 1;
                    if (exp_cnt >= halt_n) begin
                        exp_end = t; stop = 1;
                    end
                end
            end
        end
        exp_pc = pc;
    endtask

    // Reset, Start, then wait (bounded) for Busy to drop.
    task automatic exec_prog(input int hn, input bit noise, output int f, output int end_c);
        @(negedge Clock);
        Resetn = 1'b0; Start = 1'b0;
        halt_n = hn; runs_seen = 0; since_run = -1; reads = 0; run_pairs = 0; prev_run = 1'b0;
        act_run.delete(); act_w0.delete(); act_w1.delete();
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        Start = 1'b1; f = cyc + 1;
        @(negedge Clock);
        Start = 1'b0;
        end_c = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!Busy) begin
                end_c = cyc;
                break;
            end
            Start = noise && ($urandom_range(0, 7) == 0);
            @(negedge Clock);
        end
        Start = 1'b0;
        if (end_c < 0) begin
            checks++; errors++;
            $display("FAIL exec_timeout: Busy still high after 3000 cycles, expected it to drop");
        end
    endtask

    task automatic check_run(input string nm, input int f, input int e);
        check({nm, ".nruns"}, act_run.size(), exp_run.size());
        for (int i = 0; i < act_run.size() && i < exp_run.size(); i++) begin
            check($sformatf("%s.run%0d.cyc", nm, i), act_run[i] - f, exp_run[i] - f);
            check($sformatf("%s.run%0d.din", nm, i), act_w0[i], exp_w0[i]);
            check($sformatf("%s.run%0d.din2", nm, i), (i < act_w1.size()) ? int'(act_w1[i]) : -1, exp_w1[i]);
        end
        check({nm, ".end"},   e - f, exp_end - f);
        check({nm, ".pc"},    PC, exp_pc);
        check({nm, ".cnt"},   InstrCount, exp_cnt);
        check({nm, ".fault"}, Fault, exp_fault);
        check({nm, ".reads"}, reads, exp_reads);
        check({nm, ".run_pairs"}, run_pairs, 0);
    endtask

    typedef struct {
        string       nm;
        logic [15:0] w0, w1, w2;
        int          dly;
        int          hn;
        int          exp_first_run;   // offset from FETCH entry, -1 = none
        logic [15:0] exp_din2;
        int          exp_end;
        int          exp_pc;
        int          exp_cnt;
        bit          exp_fault;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int          f, e, r, mark;
        logic [2:0]  op;

        //             name          w0       w1       w2       dly hn    run din2     end pc cnt flt
        vecs.push_back('{"mvi_halt",  16'h2000, 16'h1234, 16'hE000, 1, 1000, 4, 16'h1234, 8, 2, 1, 0});
        vecs.push_back('{"add_sub",   16'h4040, 16'h6040, 16'hE000, 3, 1000, 2, 16'h4040, 14, 2, 2, 0});
        vecs.push_back('{"illegal4",  16'h8000, 16'hE000, 16'hE000, 1, 1000, -1, 16'h0000, 2, 0, 0, 1});
        vecs.push_back('{"illegal6",  16'hDFFF, 16'hE000, 16'hE000, 1, 1000, -1, 16'h0000, 2, 0, 0, 1});
        vecs.push_back('{"wd_expire", 16'h4040, 16'hE000, 16'hE000, 16, 1000, 2, 16'h4040, 18, 0, 0, 1});
        vecs.push_back('{"wd_last",   16'h4040, 16'hE000, 16'hE000, 15, 1000, 2, 16'h4040, 20, 1, 1, 0});
        vecs.push_back('{"done_inrun",16'h4040, 16'hE000, 16'hE000, 0, 1000, 2, 16'h4040, 18, 0, 0, 1});
        vecs.push_back('{"halt_op0",  16'hE000, 16'h0000, 16'h0000, 1, 1000, -1, 16'h0000, 2, 0, 0, 0});
        vecs.push_back('{"halt_pin",  16'h0000, 16'h0000, 16'hE000, 2, 1, 2, 16'h0000, 5, 1, 1, 0});
        vecs.push_back('{"halt_idle", 16'h0000, 16'h0000, 16'hE000, 1, 0, 2, 16'h0000, 4, 1, 1, 0});
        vecs.push_back('{"ill_after", 16'h4040, 16'hC000, 16'hE000, 1, 1000, 2, 16'h4040, 6, 1, 1, 1});
        vecs.push_back('{"mvi_ilimm", 16'h2000, 16'h8000, 16'hE000, 1, 1000, 4, 16'h8000, 8, 2, 1, 0});

        for (int i = 0; i < NDL; i++) dl[i] = 1;

        // Reset state.
        repeat (2) @(negedge Clock);
        check("reset.busy",  Busy, 0);
        check("reset.run",   Run, 0);
        check("reset.fault", Fault, 0);
        check("reset.memrd", mem_rd, 0);
        check("reset.din",   DIN, 0);

        // Table-driven programs.
        foreach (vecs[k]) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = 16'hE000;
            mem[0] = vecs[k].w0; mem[1] = vecs[k].w1; mem[2] = vecs[k].w2;
            for (int i = 0; i < NDL; i++) dl[i] = vecs[k].dly;
            exec_prog(vecs[k].hn, 1'b0, f, e);
            check({vecs[k].nm, ".first_run"}, (act_run.size() > 0) ? act_run[0] - f : -1, vecs[k].exp_first_run);
            if (act_run.size() > 0 && act_w1.size() > 0 && vecs[k].exp_first_run >= 0) begin
                check({vecs[k].nm, ".din"},  act_w0[0], vecs[k].w0);
                check({vecs[k].nm, ".din2"}, act_w1[0], vecs[k].exp_din2);
            end
            check({vecs[k].nm, ".end"},   e - f, vecs[k].exp_end);
            check({vecs[k].nm, ".pc"},    PC, vecs[k].exp_pc);
            check({vecs[k].nm, ".cnt"},   InstrCount, vecs[k].exp_cnt);
            check({vecs[k].nm, ".fault"}, Fault, vecs[k].exp_fault);
            model_run(f);
            check_run({vecs[k].nm, ".m"}, f, e);
        end

        // Sticky fault: Start pulses after an illegal opcode change nothing.
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'hE000;
        mem[0] = 16'h8000;
        exec_prog(1000, 1'b0, f, e);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            Start = (i % 2 == 0);
        end
        @(negedge Clock);
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        check("sticky.fault", Fault, 1);
        check("sticky.busy",  Busy, 0);
        check("sticky.runs",  runs_seen, 0);
        check("sticky.reads", reads, 1);

        // Reset mid-EXEC: mv retires, add never gets Done.
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'hE000;
        mem[0] = 16'h0000; mem[1] = 16'h4040;
        dl[0] = 1; dl[1] = 100;
        @(negedge Clock);
        Resetn = 1'b0; runs_seen = 0; since_run = -1; halt_n = 1000; prev_run = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 100 && runs_seen < 2; i++) @(negedge Clock);
        repeat (3) @(negedge Clock);
        check("rstmid.pre_pc",   PC, 1);
        check("rstmid.pre_cnt",  InstrCount, 1);
        check("rstmid.pre_busy", Busy, 1);
        Resetn = 1'b0;
        #1;
        check("rstmid.pc",    PC, 0);
        check("rstmid.cnt",   InstrCount, 0);
        check("rstmid.run",   Run, 0);
        check("rstmid.busy",  Busy, 0);
        check("rstmid.fault", Fault, 0);
        check("rstmid.din",   DIN, 0);
        check("rstmid.addr",  mem_addr, 0);
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("rstmid.start_in_reset", Busy, 0);
        mark = reads;
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check("rstmid.after_release_busy",  Busy, 0);
        check("rstmid.after_release_reads", reads, mark);

        // mvi at the last address takes its immediate from address 0, PC wraps to 1.
        mem[0] = 16'h0ABC;
        for (int a = 1; a < DEPTH - 1; a++) mem[a] = 16'(a);
        mem[DEPTH-1] = 16'h2E00;
        for (int i = 0; i < NDL; i++) dl[i] = 1;
        exec_prog(DEPTH, 1'b0, f, e);
        model_run(f);
        check_run("wrap", f, e);
        check("wrap.pc",  PC, 1);
        check("wrap.cnt", InstrCount, DEPTH);
        check("wrap.imm", (act_w1.size() > 0) ? int'(act_w1[act_w1.size()-1]) : -1, 16'h0ABC);
        mark = reads;
        repeat (4) @(negedge Clock);
        check("wrap.no_fetch", reads, mark);
        check("wrap.idle", Busy, 0);

        // Random programs against the reference model, Start noise while busy.
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                r = $urandom_range(0, 31);
                if (r < 24)      op = 3'(r % 4);
                else if (r < 28) op = 3'd7;
                else             op = 3'(4 + (r % 3));
                mem[a] = {op, 13'($urandom)};
            end
            for (int i = 0; i < NDL; i++) begin
                r = $urandom_range(0, 63);
                if (r == 0)      dl[i] = 0;
                else if (r == 1) dl[i] = 16;
                else if (r < 6)  dl[i] = 15;
                else             dl[i] = $urandom_range(1, 4);
            end
            exec_prog($urandom_range(0, 20), 1'b1, f, e);
            model_run(f);
            check_run($sformatf("rand%0d", it), f, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/issue controller for the 16-bit bus processor (mv/mvi/add/sub datapath, registers R0-R7, A/G, Tstep counter).
- Reads instruction words from a synchronous program memory and presents them on the processor's DIN with a one-cycle Run pulse.
- Supplies the mvi immediate word on the cycle after issue, waits for Done, then advances the PC.
- Adds start/halt control, a HALT opcode, illegal-opcode trapping and a Done watchdog.

Parameters:
- ADDR_W, 5, program memory address width; PC wraps modulo 2^ADDR_W.
- MAX_WAIT, 15, maximum EXEC cycles without Done before the watchdog sets Fault.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; from IDLE, starts execution at PC=0.
- Halt  in  1  level; when high at instruction retire, return to IDLE.
- mem_addr  out  ADDR_W  program memory address.
- mem_rd  out  1  read strobe; mem_rdata is valid exactly one cycle later.
- mem_rdata  in  16  program memory read data.
- DIN  out  16  word to the processor DIN.
- Run  out  1  one-cycle issue pulse; the processor captures IR = DIN[15:7] on this cycle.
- Done  in  1  processor instruction-complete flag.
- Busy  out  1  high in every state except IDLE and FAULT.
- PC  out  ADDR_W  address of the current instruction.
- InstrCount  out  16  retired-instruction counter; wraps 0xFFFF -> 0.
- Fault  out  1  sticky; illegal opcode or watchdog expiry.

Behaviour:
- Reset (Resetn low, asynchronous) forces:
  - state=IDLE; PC, InstrCount, DIN, mem_addr = 0;
  - Run, mem_rd, Busy, Fault = 0.
  - A reset mid-instruction abandons it immediately.
- Opcode field op = word[15:13]:
  - 000 mv, 001 mvi, 010 add, 011 sub: legal.
  - 111: HALT.
  - 100-110: illegal.
- States and transitions:
  - IDLE: Start=1 -> FETCH with PC=0, InstrCount=0.
  - FETCH: mem_addr=PC, mem_rd=1 -> F_WAIT.
  - F_WAIT: latch instr=mem_rdata.
    - op=111 -> IDLE; the instruction does not retire.
    - illegal op -> FAULT.
    - op=001 -> IMM_RD.
    - else -> ISSUE.
  - IMM_RD: mem_addr=(PC+1) mod 2^ADDR_W, mem_rd=1 -> IMM_WAIT.
  - IMM_WAIT: latch imm=mem_rdata -> ISSUE.
  - ISSUE: DIN=instr, Run=1 -> EXEC; watchdog counter cleared.
  - EXEC: DIN=imm for mvi, otherwise DIN holds instr; Run=0.
    - Done=1 -> retire: PC += 1 (mvi: += 2, mod 2^ADDR_W), InstrCount += 1. Then Halt=1 -> IDLE, else -> FETCH.
    - Watchdog reaches MAX_WAIT with no Done -> FAULT.
  - FAULT: Fault=1, outputs frozen; exit only by reset.
- Run is never high for more than one consecutive cycle.
- mem_rd is asserted only in FETCH and IMM_RD.
- Done is ignored outside EXEC.
- Done=1 in the same cycle Run=1 is ignored; Done is only counted from the first EXEC cycle.
- Start is ignored while Busy.
- Halt is sampled only at retire; Halt high in IDLE has no effect.
- Simultaneous Done and watchdog expiry: Done wins, the instruction retires.
- Issue latency from entering FETCH: 2 cycles to Run for mv/add/sub, 4 cycles for mvi.
- An mvi at address 2^ADDR_W-1 fetches its immediate from address 0; the PC then wraps to 1.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - adds input port Step (1 bit) and a PAUSE state;
  - after every retire with Halt=0, go to PAUSE (Busy=1);
  - a Step pulse -> FETCH; Halt=1 while in PAUSE -> IDLE.
- Undefined: no Step port, no PAUSE state; retire goes straight to FETCH.

Test Plan:
- Reset/idle: Resetn low mid-EXEC -> next cycle PC=0, Run=0, Busy=0, Fault=0, InstrCount=0; Start ignored until reset released.
- mvi + HALT: mem[0]=0x2000 (mvi R0), mem[1]=0x1234, mem[2]=0xE000; Start, Done 1 cycle after Run -> Run with DIN=0x2000, next cycle DIN=0x1234; PC becomes 2; HALT returns to IDLE; InstrCount=1.
- add sequence: mem[0]=0x4040 (add), mem[1]=0x6040 (sub), mem[2]=0xE000; Done 3 cycles after each Run -> Run issued 2 cycles after each FETCH entry; final InstrCount=2, PC=2.
- Illegal opcode: mem[0]=0x8000 -> Fault=1 two cycles after FETCH, Run never asserted, Busy=0, Fault stays high until reset.
- Watchdog: MAX_WAIT=15, Done held low -> Fault=1 after 15 EXEC cycles; with Done arriving on cycle 15 instead -> retire, no Fault.
- Wrap/Halt: ADDR_W=5, mvi at address 31 with imm in mem[0] -> DIN=mem[0] on cycle after Run; PC=1. Halt=1 at that retire -> IDLE, no further fetch.
